// File: rtl/obj_sprite_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obj_sprite_engine_pkg
// Brief   : Shared widths, atlas constants and slot-config type for the sprite engine.
// Revision: 1.0 - initial release
// ============================================================================
package obj_sprite_engine_pkg;

  localparam int CNT_W           = 10;     // VGA counter width
  localparam int LC_W            = 9;      // logical coordinate width
  localparam int ATLAS_W_DEF     = 320;
  localparam int ATLAS_SIZE_DEF  = 76800;
  localparam int ADDR_W_DEF      = 17;

  typedef struct packed {
    logic [LC_W-1:0] x;
    logic [LC_W-1:0] y;
    logic [LC_W-1:0] ax;
    logic [LC_W-1:0] ay;
    logic            en;
    logic            blink;
    logic            alt;
  } slot_cfg_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obj_sprite_engine_hit_test.sv
`default_nettype none
// ============================================================================
// Module  : obj_hit_test
// Brief   : Per-slot bounds test and in-sprite offset for one logical pixel.
// Revision: 1.0 - initial release
// ============================================================================
module obj_hit_test
  import obj_sprite_engine_pkg::*;
#(
  parameter int OBJ_W = 20,
  parameter int OBJ_H = 20
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  slot_cfg_t        cfg,
  output logic             hit,
  output logic [LC_W-1:0]  dx,
  output logic [LC_W-1:0]  dy
);

  logic [CNT_W-1:0] ox_w;
  logic [CNT_W-1:0] oy_w;
  logic [CNT_W-1:0] dx_full;
  logic [CNT_W-1:0] dy_full;

  // Compare one bit wider than the config so ox+OBJ_W cannot wrap past 511.
  always_comb begin
    ox_w    = CNT_W'(cfg.x);
    oy_w    = CNT_W'(cfg.y);
    hit     = (x >= ox_w) && (x < ox_w + CNT_W'(OBJ_W)) &&
              (y >= oy_w) && (y < oy_w + CNT_W'(OBJ_H));
    dx_full = x - ox_w;
    dy_full = y - oy_w;
    dx      = dx_full[LC_W-1:0];
    dy      = dy_full[LC_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/obj_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module  : obj_sprite_engine
// Brief   : N-slot sprite overlay: priority select, atlas addressing, blink, alt frame.
// Revision: 1.0 - initial release
// ============================================================================
module obj_sprite_engine
  import obj_sprite_engine_pkg::*;
#(
  parameter int N_OBJ      = 4,
  parameter int OBJ_W      = 20,
  parameter int OBJ_H      = 20,
  parameter int SCALE_SH   = 1,
  parameter int ATLAS_W    = ATLAS_W_DEF,
  parameter int ATLAS_SIZE = ATLAS_SIZE_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BLINK_DIV  = 30,
  localparam int IW        = idx_w(N_OBJ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [CNT_W-1:0]  h_cnt,
  input  logic [CNT_W-1:0]  v_cnt,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [LC_W-1:0]   cfg_x,
  input  logic [LC_W-1:0]   cfg_y,
  input  logic [LC_W-1:0]   cfg_ax,
  input  logic [LC_W-1:0]   cfg_ay,
  input  logic              cfg_en,
  input  logic              cfg_blink,
  input  logic              cfg_alt,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              is_object,
  output logic [IW-1:0]     obj_id
);

  localparam int BC_W = idx_w(BLINK_DIV);
  localparam int AW   = ADDR_W + 3;

  slot_cfg_t [N_OBJ-1:0]            shadow_q, shadow_d, active_q, active_d;
  logic [BC_W-1:0]                  blink_cnt_q, blink_cnt_d;
  logic                             blink_ph_q, blink_ph_d;
  logic                             s1_valid_q, s1_valid_d;
  logic [N_OBJ-1:0]                 s1_hit_q, s1_hit_d;
  logic [N_OBJ-1:0][LC_W-1:0]       s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic [N_OBJ-1:0][LC_W-1:0]       s1_ax_q, s1_ax_d, s1_ay_q, s1_ay_d;
  logic [N_OBJ-1:0]                 s1_alt_q, s1_alt_d;
  logic                             out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]                pixel_addr_q, pixel_addr_d;
  logic                             is_object_q, is_object_d;
  logic [IW-1:0]                    obj_id_q, obj_id_d;

  logic [CNT_W-1:0]                 x_log, y_log;
  logic [N_OBJ-1:0]                 raw_hit;
  logic [N_OBJ-1:0][LC_W-1:0]       dx_w, dy_w;
  logic                             found;
  logic [IW-1:0]                    sel;
  logic [LC_W-1:0]                  sel_ax, sel_ay, sel_dx, sel_dy;
  logic                             sel_alt;
  logic [AW-1:0]                    addr_sum;

  assign x_log = h_cnt >> SCALE_SH;
  assign y_log = v_cnt >> SCALE_SH;

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_hit
    obj_hit_test #(
      .OBJ_W (OBJ_W),
      .OBJ_H (OBJ_H)
    ) u_hit (
      .x   (x_log),
      .y   (y_log),
      .cfg (active_q[gi]),
      .hit (raw_hit[gi]),
      .dx  (dx_w[gi]),
      .dy  (dy_w[gi])
    );
  end

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (cfg_idx == IW'(i)) begin
          shadow_d[i].x     = cfg_x;
          shadow_d[i].y     = cfg_y;
          shadow_d[i].ax    = cfg_ax;
          shadow_d[i].ay    = cfg_ay;
          shadow_d[i].en    = cfg_en;
          shadow_d[i].blink = cfg_blink;
          shadow_d[i].alt   = cfg_alt;
        end
      end
    end
    // Takes the pre-write shadow, so a same-cycle write waits for the next frame.
    active_d    = frame_start ? shadow_q : active_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_start) begin
      if (blink_cnt_q == BC_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    s1_valid_d = pix_valid;
    for (int i = 0; i < N_OBJ; i++) begin
      s1_hit_d[i] = pix_valid && raw_hit[i] && active_q[i].en &&
                    !(active_q[i].blink && blink_ph_q);
      s1_ax_d[i]  = active_q[i].ax;
      s1_ay_d[i]  = active_q[i].ay;
      s1_alt_d[i] = active_q[i].alt;
    end
    s1_dx_d = dx_w;
    s1_dy_d = dy_w;

    found   = 1'b0;
    sel     = '0;
    sel_ax  = '0;
    sel_ay  = '0;
    sel_dx  = '0;
    sel_dy  = '0;
    sel_alt = 1'b0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        found   = 1'b1;
        sel     = IW'(i);
        sel_ax  = s1_ax_q[i];
        sel_ay  = s1_ay_q[i];
        sel_dx  = s1_dx_q[i];
        sel_dy  = s1_dy_q[i];
        sel_alt = s1_alt_q[i];
      end
    end
    addr_sum = AW'(sel_ax) + AW'(sel_dx) + (sel_alt ? AW'(OBJ_W) : AW'(0)) +
               (AW'(sel_ay) + AW'(sel_dy)) * AW'(ATLAS_W);

    out_valid_d  = s1_valid_q;
    is_object_d  = s1_valid_q && found;
    pixel_addr_d = is_object_d ? ADDR_W'(addr_sum % AW'(ATLAS_SIZE)) : '0;
    obj_id_d     = is_object_d ? sel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      active_q     <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_hit_q     <= '0;
      s1_dx_q      <= '0;
      s1_dy_q      <= '0;
      s1_ax_q      <= '0;
      s1_ay_q      <= '0;
      s1_alt_q     <= '0;
      out_valid_q  <= 1'b0;
      pixel_addr_q <= '0;
      is_object_q  <= 1'b0;
      obj_id_q     <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      s1_valid_q   <= s1_valid_d;
      s1_hit_q     <= s1_hit_d;
      s1_dx_q      <= s1_dx_d;
      s1_dy_q      <= s1_dy_d;
      s1_ax_q      <= s1_ax_d;
      s1_ay_q      <= s1_ay_d;
      s1_alt_q     <= s1_alt_d;
      out_valid_q  <= out_valid_d;
      pixel_addr_q <= pixel_addr_d;
      is_object_q  <= is_object_d;
      obj_id_q     <= obj_id_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign pixel_addr = pixel_addr_q;
  assign is_object  = is_object_q;
  assign obj_id     = obj_id_q;

endmodule
`default_nettype wire

// File: tb/tb_obj_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_obj_sprite_engine
// Brief   : Directed, table-driven bench for obj_sprite_engine (BLINK_DIV=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_obj_sprite_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, pix_valid, cfg_we;
  logic [9:0]  h_cnt, v_cnt;
  logic [1:0]  cfg_idx;
  logic [8:0]  cfg_x, cfg_y, cfg_ax, cfg_ay;
  logic        cfg_en, cfg_blink, cfg_alt;
  logic        out_valid, is_object;
  logic [16:0] pixel_addr;
  logic [1:0]  obj_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obj_sprite_engine #(.BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_ax(cfg_ax), .cfg_ay(cfg_ay),
    .cfg_en(cfg_en), .cfg_blink(cfg_blink), .cfg_alt(cfg_alt),
    .out_valid(out_valid), .pixel_addr(pixel_addr), .is_object(is_object), .obj_id(obj_id)
  );

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        pv;
    logic        ev;
    logic        eo;
    logic [16:0] ea;
    logic [1:0]  ei;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic eo,
                         input logic [16:0] ea, input logic [1:0] ei);
    chk({nm, ".valid"}, 32'(out_valid), 32'(ev));
    chk({nm, ".obj"},   32'(is_object), 32'(eo));
    chk({nm, ".addr"},  32'(pixel_addr), 32'(ea));
    chk({nm, ".id"},    32'(obj_id), 32'(ei));
  endtask

  task automatic check_pix(input string nm, input logic [9:0] h, input logic [9:0] v,
                           input logic pv, input logic ev, input logic eo,
                           input logic [16:0] ea, input logic [1:0] ei);
    h_cnt = h; v_cnt = v; pix_valid = pv;
    tick(); tick();
    chk_out(nm, ev, eo, ea, ei);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [8:0] x, input logic [8:0] y,
                           input logic [8:0] ax, input logic [8:0] ay,
                           input logic en, input logic bl, input logic alt);
    cfg_we = 1'b1; cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_ax = ax; cfg_ay = ay;
    cfg_en = en; cfg_blink = bl; cfg_alt = alt;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    logic vis_exp[5];
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; cfg_we = 1'b0;
    h_cnt = '0; v_cnt = '0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
    cfg_ax = '0; cfg_ay = '0; cfg_en = 1'b0; cfg_blink = 1'b0; cfg_alt = 1'b0;

    vecs[0]  = '{10'd130,  10'd70,   1'b1, 1'b1, 1'b1, 17'd25600, 2'd0};
    vecs[1]  = '{10'd170,  10'd70,   1'b1, 1'b1, 1'b0, 17'd0,     2'd0};
    vecs[2]  = '{10'd168,  10'd70,   1'b1, 1'b1, 1'b1, 17'd25619, 2'd0};
    vecs[3]  = '{10'd130,  10'd108,  1'b1, 1'b1, 1'b1, 17'd31680, 2'd0};
    vecs[4]  = '{10'd130,  10'd110,  1'b1, 1'b1, 1'b0, 17'd0,     2'd0};
    vecs[5]  = '{10'd129,  10'd71,   1'b1, 1'b1, 1'b0, 17'd0,     2'd0};
    vecs[6]  = '{10'd131,  10'd71,   1'b1, 1'b1, 1'b1, 17'd25600, 2'd0};
    vecs[7]  = '{10'd200,  10'd200,  1'b1, 1'b1, 1'b1, 17'd3230,  2'd1};
    vecs[8]  = '{10'd20,   10'd58,   1'b1, 1'b1, 1'b1, 17'd5860,  2'd3};
    vecs[9]  = '{10'd18,   10'd58,   1'b1, 1'b1, 1'b0, 17'd0,     2'd0};
    vecs[10] = '{10'd20,   10'd20,   1'b1, 1'b1, 1'b1, 17'd76580, 2'd3};
    vecs[11] = '{10'd130,  10'd70,   1'b0, 1'b0, 1'b0, 17'd0,     2'd0};
    vecs[12] = '{10'd1022, 10'd1022, 1'b1, 1'b1, 1'b0, 17'd0,     2'd0};

    tick(); tick();
    chk_out("reset", 1'b0, 1'b0, 17'd0, 2'd0);
    rst_n = 1'b1;
    tick();

    cfg_write(2'd0, 9'd65, 9'd35, 9'd0,  9'd80,  1'b1, 1'b0, 1'b0);
    cfg_write(2'd1, 9'd90, 9'd90, 9'd20, 9'd0,   1'b1, 1'b0, 1'b0);
    cfg_write(2'd2, 9'd95, 9'd95, 9'd40, 9'd0,   1'b1, 1'b0, 1'b0);
    cfg_write(2'd3, 9'd10, 9'd10, 9'd80, 9'd239, 1'b1, 1'b0, 1'b1);
    check_pix("pre_frame", 10'd130, 10'd70, 1'b1, 1'b1, 1'b0, 17'd0, 2'd0);
    fs();

    for (int i = 0; i < 13; i++)
      check_pix($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].pv,
                vecs[i].ev, vecs[i].eo, vecs[i].ea, vecs[i].ei);

    // Right edge: ox=500 must not wrap to small x.
    cfg_write(2'd3, 9'd500, 9'd0, 9'd80, 9'd239, 1'b1, 1'b0, 1'b1);
    fs();
    check_pix("edge_hit",  10'd1022, 10'd0, 1'b1, 1'b1, 1'b1, 17'd76591, 2'd3);
    check_pix("edge_wrap", 10'd10,   10'd0, 1'b1, 1'b1, 1'b0, 17'd0,     2'd0);

    cfg_write(2'd1, 9'd90, 9'd90, 9'd20, 9'd0, 1'b0, 1'b0, 1'b0);
    check_pix("dis1_before", 10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 17'd3230, 2'd1);
    fs();
    check_pix("dis1_after",  10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 17'd1645, 2'd2);

    // Write coinciding with frame_start is held back one frame.
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_x = 9'd95; cfg_y = 9'd95; cfg_ax = 9'd40;
    cfg_ay = 9'd0; cfg_en = 1'b0; cfg_blink = 1'b0; cfg_alt = 1'b0;
    frame_start = 1'b1;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
    check_pix("shadow_same", 10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 17'd1645, 2'd2);
    fs();
    check_pix("shadow_next", 10'd200, 10'd200, 1'b1, 1'b1, 1'b0, 17'd0, 2'd0);

    // Single-cycle pixel emerges exactly two cycles later.
    pix_valid = 1'b0; tick(); tick();
    h_cnt = 10'd130; v_cnt = 10'd70; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("lat1.valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat2.valid", 32'(out_valid), 32'd1);
    chk("lat2.addr",  32'(pixel_addr), 32'd25600);
    tick();
    chk("lat3.valid", 32'(out_valid), 32'd0);
    chk("lat3.obj",   32'(is_object), 32'd0);

    // Asynchronous reset mid-frame.
    h_cnt = 10'd130; v_cnt = 10'd70; pix_valid = 1'b1;
    tick(); tick();
    chk("prerst.obj", 32'(is_object), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 17'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel1.valid", 32'(out_valid), 32'd0);
    tick();
    chk_out("rel2", 1'b1, 1'b0, 17'd0, 2'd0);
    check_pix("rst_cfg", 10'd200, 10'd200, 1'b1, 1'b1, 1'b0, 17'd0, 2'd0);

    // Blink with BLINK_DIV=2: visible / hidden / hidden / visible / visible.
    cfg_write(2'd0, 9'd65, 9'd35, 9'd0,  9'd80, 1'b1, 1'b1, 1'b0);
    cfg_write(2'd1, 9'd90, 9'd90, 9'd20, 9'd0,  1'b1, 1'b0, 1'b0);
    vis_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      fs();
      check_pix($sformatf("blink_f%0d", k + 1), 10'd130, 10'd70, 1'b1, 1'b1,
                vis_exp[k], vis_exp[k] ? 17'd25600 : 17'd0, 2'd0);
      check_pix($sformatf("steady_f%0d", k + 1), 10'd200, 10'd200, 1'b1, 1'b1,
                1'b1, 17'd3230, 2'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
